or16bit: RTL and testbench
==========================

# or16bit

16-bit bitwise OR for the NAND-built datapath library. Each bit is formed from NAND primitives: `out[i] = NAND(NAND(inA[i],inA[i]), NAND(inB[i],inB[i]))`. A zero-latency combinational result feeds the ALU and downstream logic directly. A registered copy with a valid flag and a reduction flag serves pipelined consumers.

## Interface

Parameters:
- `WIDTH`, default 16: word width. The bench and all tests use 16. The combinational path must be correct for any `WIDTH` ≥ 1.

Ports:
- `clk`  input  1: single clock; all registers update on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `inA`  input  WIDTH: operand A.
- `inB`  input  WIDTH: operand B.
- `in_valid`  input  1: qualifies `inA`/`inB` for the registered path.
- `out`  output  WIDTH: combinational `inA | inB`.
- `out_q`  output  WIDTH: registered `inA | inB`.
- `out_valid`  output  1: `out_q` holds a result captured from a valid input.
- `any_q`  output  1: registered reduction OR of the result, i.e. `|(inA | inB)`.

One clock; reset is asynchronous and active-low.

## Operation

- **Combinational path**
  - `out[i] = inA[i] | inB[i]` for every bit i.
  - Implemented structurally: per bit, one NAND-based OR cell (three 2-input NANDs), generated WIDTH times.
  - Behavioural `|` is not permitted inside the cell.
  - `out` is independent of `clk`, `rst_n` and `in_valid`; reset never forces `out`.
- **Registered path**
  - When `in_valid` = 1 at a rising edge: `out_q <= out`, `any_q <= |out`, `out_valid <= 1`.
  - When `in_valid` = 0 at a rising edge: `out_q` and `any_q` hold their values, and `out_valid <= 0`.
- **Reset**
  - While `rst_n` = 0: `out_q` = 0, `any_q` = 0, `out_valid` = 0, asynchronously on the falling edge of `rst_n`.
  - The first capture is at the first rising edge with `rst_n` = 1 and `in_valid` = 1.
- **X handling**
  - An X on `inA[i]` or `inB[i]` propagates to `out[i]` unless the other operand bit is 1, in which case `out[i]` = 1.

## Timing

- `out`: zero-cycle latency; settles within one simulation time unit of any input change.
- `out_q`, `any_q`, `out_valid`: one-cycle latency from the sampled `in_valid` edge.
- Throughput is one result per cycle. There is no backpressure and no handshake beyond `in_valid`.
- Reset asserted mid-stream clears registered outputs immediately. Inputs presented during reset are discarded.
- Reset deasserts synchronously to the design; `rst_n` must rise at least setup time before the next `clk` edge.
- Back-to-back valid inputs overwrite `out_q` each cycle; no result is buffered.

## Test plan

- **All-zero / all-one:**
  - `inA`=0000, `inB`=0000 -> `out`=0000 after 1 time unit.
  - `inA`=0000, `inB`=FFFF -> `out`=FFFF.
  - `inA`=FFFF, `inB`=FFFF -> `out`=FFFF.
- **Alternating / mixed patterns:**
  - AAAA | 5555 -> FFFF.
  - 3CC3 | 0FF0 -> 3FF3.
  - 1234 | 9876 -> 9A76.
  - Check all results with `===`.
- **Registered capture:**
  - After reset, drive 1234/9876 with `in_valid`=1 for one edge -> `out_q`=9A76, `any_q`=1, `out_valid`=1 one cycle later.
  - Next edge with `in_valid`=0 -> `out_valid`=0 and `out_q` still 9A76.
- **Reduction flag:**
  - Valid 0000/0000 -> `any_q`=0, `out_q`=0000.
  - Valid 0001/0000 -> `any_q`=1.
- **Asynchronous reset mid-operation:**
  - With `out_q`=FFFF, drop `rst_n` between clock edges -> `out_q`=0000, `any_q`=0, `out_valid`=0 before the next edge.
  - `out` still equals `inA | inB` during reset.
- **Walking one:**
  - For each i in 0..15, `inA` = 1<<i, `inB`=0 -> `out` = 1<<i.
  - Repeat with operands swapped.

Source files
------------

// File: rtl/or16bit.sv
// or16bit: bitwise OR built from 2-input NAND cells, with a
// valid-qualified registered copy and a reduction-OR flag.
module or16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             any_q
);

  // Per-bit OR cell: y = NAND(NAND(a,a), NAND(b,b)).
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic na;
    logic nb;
    assign na     = ~(inA[i] & inA[i]);
    assign nb     = ~(inB[i] & inB[i]);
    assign out[i] = ~(na & nb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      any_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
        any_q <= |out;
      end
    end
  end

endmodule

// File: tb/tb_or16bit.sv
// tb_or16bit: random and directed stimulus; registered results
// are checked through a scoreboard queue by a separate monitor.
module tb_or16bit;

  typedef struct packed {
    logic [15:0] val;
    logic        any;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] inA = '0;
  logic [15:0] inB = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out;
  logic [15:0] out_q;
  logic        out_valid;
  logic        any_q;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        sb[$];
  logic [15:0] last_q = '0;
  logic        last_any = 1'b0;

  or16bit #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inA      (inA),
    .inB      (inB),
    .in_valid (in_valid),
    .out      (out),
    .out_q    (out_q),
    .out_valid(out_valid),
    .any_q    (any_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain OR, reduction is "result nonzero".
  function automatic exp_t model(input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    e.val = a | b;
    e.any = (e.val != 16'h0000);
    return e;
  endfunction

  // Monitor: pops one expectation per valid output; otherwise
  // the registered outputs must hold the last captured result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        exp_t e;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: out_valid=1 with no pending result");
        end else begin
          e = sb.pop_front();
          check("out_q", out_q, e.val);
          check("any_q", {15'b0, any_q}, {15'b0, e.any});
          last_q   = e.val;
          last_any = e.any;
        end
      end else begin
        check("hold_q", out_q, last_q);
        check("hold_any", {15'b0, any_q}, {15'b0, last_any});
      end
    end
  end

  task automatic drive(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic v);
    @(negedge clk);
    inA      = a;
    inB      = b;
    in_valid = v;
    if (v && rst_n) sb.push_back(model(a, b));
    #1;
    check("out_comb", out, model(a, b).val);
  endtask

  initial begin
    logic [15:0] pa[6];
    logic [15:0] pb[6];
    logic [15:0] one;
    pa = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
    pb = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0FF0, 16'h9876};

    // Reset state and combinational path during reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_q", out_q, 16'h0000);
    check("rst_any", {15'b0, any_q}, 16'h0000);
    check("rst_valid", {15'b0, out_valid}, 16'h0000);
    inA = 16'h1234;
    inB = 16'h9876;
    #1;
    check("rst_comb", out, 16'h9A76);
    @(negedge clk);
    inA = '0;
    inB = '0;
    #2 rst_n = 1'b1;

    // Directed patterns, each captured as valid.
    for (int i = 0; i < 6; i++) drive(pa[i], pb[i], 1'b1);
    drive(16'h0000, 16'h0000, 1'b0);

    drive(16'h1234, 16'h9876, 1'b1);
    drive(16'h1234, 16'h9876, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0);
    drive(16'h0000, 16'h0000, 1'b1);
    drive(16'h0001, 16'h0000, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0);

    // Walking one, both operand orders.
    for (int i = 0; i < 16; i++) begin
      one = 16'h0001 << i;
      drive(one, 16'h0000, i[0]);
      check("walk_a", out, one);
      drive(16'h0000, one, ~i[0]);
      check("walk_b", out, one);
    end

    // Random traffic with random valid gaps.
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 65535), $urandom_range(0, 65535),
            ($urandom_range(0, 3) != 0));

    // Asynchronous reset between edges with out_q = FFFF.
    drive(16'hFFFF, 16'h0000, 1'b1);
    drive(16'h00F0, 16'h0F00, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_q", out_q, 16'h0000);
    check("arst_any", {15'b0, any_q}, 16'h0000);
    check("arst_valid", {15'b0, out_valid}, 16'h0000);
    check("arst_comb", out, 16'h0FF0);
    sb.delete();
    last_q   = '0;
    last_any = 1'b0;
    drive(16'hBEEF, 16'h0000, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0);
    #2 rst_n = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0);
    drive(16'h8000, 16'h0001, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 16'(sb.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
